usb_tx_encoder: RTL and testbench

// - USB full-speed packet transmitter; drains the endpoint data buffer through its TX read port.
// - Serialises SYNC, PID, optional DATA payload, CRC16 and EOP onto the D+/D- line pair.
// - Applies bit stuffing and NRZI encoding. Started by a one-cycle packet command from the protocol controller.

---
 rtl/usb_tx_encoder.sv | 190 +++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter: SYNC, PID, optional payload with CRC16, EOP,
// with bit stuffing and NRZI onto the D+/D- pair. Payload bytes are pulled from the endpoint buffer.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] TX_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] TX_packet_data,
    output logic       get_TX_packet_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       TX_transfer_active,
    output logic       TX_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
    } state_t;

    state_t        state_reg;
    state_t        nxt_state;
    logic [TW-1:0] timer_reg;
    logic [2:0]    cmd_reg;
    logic [6:0]    byte_count_reg;
    logic [6:0]    nxt_count;
    logic [7:0]    shift_reg;
    logic [7:0]    hold_reg;
    logic [7:0]    nxt_byte;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    nxt_idx;
    logic [2:0]    ones_reg;
    logic [15:0]   crc_reg;
    logic [15:0]   crc_upd;
    logic          line_reg;
    logic          nxt_line;
    logic          nxt_bit;
    logic [3:0]    pid_code;
    logic          is_data;
    logic          want_get;
    logic          cmd_valid;

    assign cmd_valid = (TX_packet >= 3'd1) && (TX_packet <= 3'd5);

    always_comb begin
        case (cmd_reg)
            3'd2:    pid_code = 4'b1011;
            3'd3:    pid_code = 4'b0010;
            3'd4:    pid_code = 4'b1010;
            3'd5:    pid_code = 4'b1110;
            default: pid_code = 4'b0011;
        endcase
        is_data = (cmd_reg == 3'd1) || (cmd_reg == 3'd2);
    end

    // Position of the next unstuffed bit: same byte, or the first bit of the next field.
    always_comb begin
        nxt_state = state_reg;
        nxt_idx   = bit_idx_reg + 3'd1;
        nxt_byte  = shift_reg;
        nxt_count = byte_count_reg;
        if (bit_idx_reg == 3'd7) begin
            case (state_reg)
                SYNC: begin
                    nxt_state = PID;
                    nxt_byte  = {~pid_code, pid_code};
                end
                PID, DATA: begin
                    if (state_reg == PID && !is_data) begin
                        nxt_state = EOP_SE0;
                    end else if (byte_count_reg != 7'd0) begin
                        nxt_state = DATA;
                        nxt_byte  = hold_reg;
                        nxt_count = byte_count_reg - 7'd1;
                    end else begin
                        nxt_state = CRC_LO;
                        nxt_byte  = ~crc_reg[7:0];
                    end
                end
                CRC_LO: begin
                    nxt_state = CRC_HI;
                    nxt_byte  = ~crc_reg[15:8];
                end
                CRC_HI:  nxt_state = EOP_SE0;
                default: nxt_state = state_reg;
            endcase
        end
        nxt_bit  = nxt_byte[nxt_idx];
        nxt_line = nxt_bit ? line_reg : ~line_reg;
        crc_upd  = {1'b0, crc_reg[15:1]} ^ (((crc_reg[0] ^ nxt_bit) != 1'b0) ? 16'hA001 : 16'h0000);
        // The fetch for the next payload byte rides on the last bit of the current byte.
        want_get = (nxt_idx == 3'd7) && (nxt_count != 7'd0) &&
                   ((nxt_state == PID && is_data) || nxt_state == DATA);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg          <= IDLE;
            timer_reg          <= '0;
            cmd_reg            <= 3'd0;
            byte_count_reg     <= 7'd0;
            shift_reg          <= 8'd0;
            hold_reg           <= 8'd0;
            bit_idx_reg        <= 3'd0;
            ones_reg           <= 3'd0;
            crc_reg            <= 16'hFFFF;
            line_reg           <= 1'b1;
            dp_out             <= 1'b1;
            dm_out             <= 1'b0;
            get_TX_packet_data <= 1'b0;
            TX_transfer_active <= 1'b0;
            TX_error           <= 1'b0;
        end else begin
            get_TX_packet_data <= 1'b0;
            TX_error           <= 1'b0;
            if (get_TX_packet_data)
                hold_reg <= TX_packet_data;

            if (state_reg == IDLE) begin
                if (cmd_valid) begin
                    state_reg          <= SYNC;
                    cmd_reg            <= TX_packet;
                    byte_count_reg     <= buffer_occupancy;
                    shift_reg          <= SYNC_BYTE;
                    bit_idx_reg        <= 3'd0;
                    timer_reg          <= '0;
                    ones_reg           <= 3'd0;
                    crc_reg            <= 16'hFFFF;
                    TX_transfer_active <= 1'b1;
                    // SYNC bit 0 is a 0, so the line leaves J for K right away.
                    line_reg           <= 1'b0;
                    dp_out             <= 1'b0;
                    dm_out             <= 1'b1;
                end else if (TX_packet[2:1] == 2'b11) begin
                    TX_error <= 1'b1;
                end
            end else if (timer_reg != TIMER_MAX) begin
                timer_reg <= timer_reg + TW'(1);
            end else begin
                timer_reg <= '0;
                case (state_reg)
                    EOP_SE0: begin
                        if (bit_idx_reg == 3'd0) begin
                            bit_idx_reg <= 3'd1;
                        end else begin
                            state_reg <= EOP_J;
                            dp_out    <= 1'b1;
                            dm_out    <= 1'b0;
                        end
                    end
                    EOP_J: begin
                        state_reg          <= IDLE;
                        TX_transfer_active <= 1'b0;
                    end
                    default: begin
                        if (ones_reg == 3'd6) begin
                            // Stuffed zero: position, CRC and fetch timing all hold for one period.
                            ones_reg <= 3'd0;
                            line_reg <= ~line_reg;
                            dp_out   <= ~line_reg;
                            dm_out   <= line_reg;
                        end else begin
                            state_reg      <= nxt_state;
                            bit_idx_reg    <= nxt_idx;
                            shift_reg      <= nxt_byte;
                            byte_count_reg <= nxt_count;
                            if (nxt_state == EOP_SE0) begin
                                line_reg <= 1'b1;
                                dp_out   <= 1'b0;
                                dm_out   <= 1'b0;
                            end else begin
                                line_reg           <= nxt_line;
                                dp_out             <= nxt_line;
                                dm_out             <= ~nxt_line;
                                ones_reg           <= nxt_bit ? ones_reg + 3'd1 : 3'd0;
                                get_TX_packet_data <= want_get;
                                if (nxt_state == DATA)
                                    crc_reg <= crc_upd;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: expected line waveform built from a
// byte-level packet model (stuffing + NRZI), plus decode of the driven line.
module tb_usb_tx_encoder;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] TX_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] TX_packet_data;
    logic       get_TX_packet_data;
    logic       dp_out;
    logic       dm_out;
    logic       TX_transfer_active;
    logic       TX_error;

    int total = 0;
    int bad = 0;

    logic [7:0] buf_mem [0:63];
    logic [5:0] rd_ptr = 6'd0;

    logic [7:0] pay_q[$];
    bit         exp_lvl_q[$];
    bit         exp_se0_q[$];
    bit         exp_get_q[$];
    logic [7:0] rx_bytes_q[$];
    int         last_active_clks;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .TX_packet          (TX_packet),
        .buffer_occupancy   (buffer_occupancy),
        .TX_packet_data     (TX_packet_data),
        .get_TX_packet_data (get_TX_packet_data),
        .dp_out             (dp_out),
        .dm_out             (dm_out),
        .TX_transfer_active (TX_transfer_active),
        .TX_error           (TX_error)
    );

    always #5 clk = ~clk;

    // Endpoint buffer: head byte presented combinationally, popped by the strobe.
    assign TX_packet_data = buf_mem[rd_ptr];
    always @(posedge clk) if (get_TX_packet_data) rd_ptr <= rd_ptr + 6'd1;

    function automatic logic [7:0] pid_byte(input logic [2:0] cmd);
        case (cmd)
            3'd1:    return 8'hC3;
            3'd2:    return 8'h4B;
            3'd3:    return 8'hD2;
            3'd4:    return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    // CRC-16/USB over the payload, bytewise reflected form; returns the field as sent.
    function automatic logic [15:0] crc_field(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, pay_q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_model(input logic [2:0] cmd, input int n);
        logic [7:0]  bytes_q[$];
        logic [15:0] crc;
        int          ones;
        bit          lvl;
        bit          b;
        bit          is_data;
        exp_lvl_q.delete();
        exp_se0_q.delete();
        exp_get_q.delete();
        is_data = (cmd == 3'd1) || (cmd == 3'd2);
        bytes_q.push_back(8'h80);
        bytes_q.push_back(pid_byte(cmd));
        if (is_data) begin
            for (int i = 0; i < n; i++) bytes_q.push_back(pay_q[i]);
            crc = crc_field(n);
            bytes_q.push_back(crc[7:0]);
            bytes_q.push_back(crc[15:8]);
        end
        ones = 0;
        lvl  = 1'b1;
        for (int i = 0; i < bytes_q.size(); i++) begin
            for (int j = 0; j < 8; j++) begin
                b = bytes_q[i][j];
                if (!b) lvl = !lvl;
                exp_lvl_q.push_back(lvl);
                exp_se0_q.push_back(1'b0);
                exp_get_q.push_back(j == 7 && is_data && i >= 1 && i <= n);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = !lvl;
                    exp_lvl_q.push_back(lvl);
                    exp_se0_q.push_back(1'b0);
                    exp_get_q.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        repeat (2) begin
            exp_lvl_q.push_back(1'b0);
            exp_se0_q.push_back(1'b1);
            exp_get_q.push_back(1'b0);
        end
        exp_lvl_q.push_back(1'b1);
        exp_se0_q.push_back(1'b0);
        exp_get_q.push_back(1'b0);
    endtask

    task automatic run_packet(input logic [2:0] cmd, input int tail, input string name);
        int n, b, clks, gets, act_cnt, err_cnt;
        int line_bad, act_bad, get_bad, first_line;
        logic [1:0] got_line, need_line;
        bit exp_act, exp_get, exp_dp, exp_dm, is_data;
        bit lv[$], se[$];
        bit prev, rb, skip;
        int ones, cnt;
        logic [7:0] cur;
        is_data = (cmd == 3'd1) || (cmd == 3'd2);
        n = is_data ? pay_q.size() : 0;
        for (int i = 0; i < n; i++) buf_mem[rd_ptr + 6'(i)] = pay_q[i];
        build_model(cmd, n);
        clks = exp_lvl_q.size() * CPB;
        gets = 0; act_cnt = 0; err_cnt = 0;
        line_bad = 0; act_bad = 0; get_bad = 0; first_line = -1;
        got_line = 2'b00; need_line = 2'b00;
        @(negedge clk);
        TX_packet = cmd;
        buffer_occupancy = is_data ? 7'(n) : 7'($urandom_range(64, 0));
        @(posedge clk);
        for (int k = 0; k < clks + tail; k++) begin
            @(negedge clk);
            // A command while busy must be ignored; occupancy after accept must be ignored.
            TX_packet = (k == 3 * CPB + 2) ? 3'($urandom_range(7, 1)) : 3'd0;
            buffer_occupancy = 7'($urandom_range(64, 0));
            if (k < clks) begin
                b = k / CPB;
                exp_act = 1'b1;
                exp_get = exp_get_q[b] && (k % CPB == 0);
                exp_dp  = exp_se0_q[b] ? 1'b0 : exp_lvl_q[b];
                exp_dm  = exp_se0_q[b] ? 1'b0 : !exp_lvl_q[b];
                if (k % CPB == CPB / 2) begin
                    lv.push_back(dp_out);
                    se.push_back(!dp_out && !dm_out);
                end
            end else begin
                exp_act = 1'b0; exp_get = 1'b0; exp_dp = 1'b1; exp_dm = 1'b0;
            end
            if ({dp_out, dm_out} !== {exp_dp, exp_dm}) begin
                if (first_line < 0) begin
                    first_line = k;
                    got_line = {dp_out, dm_out};
                    need_line = {exp_dp, exp_dm};
                end
                line_bad++;
            end
            if (TX_transfer_active !== exp_act) act_bad++;
            if (get_TX_packet_data !== exp_get) get_bad++;
            if (TX_transfer_active === 1'b1) act_cnt++;
            if (get_TX_packet_data === 1'b1) gets++;
            if (TX_error !== 1'b0) err_cnt++;
        end
        TX_packet = 3'd0;
        last_active_clks = act_cnt;

        total++;
        if (line_bad != 0) begin
            bad++;
            $display("FAIL %s line: %0d wrong clocks, first clk %0d dp/dm got %b need %b",
                     name, line_bad, first_line, got_line, need_line);
        end
        total++;
        if (act_bad != 0) begin
            bad++;
            $display("FAIL %s active: %0d wrong clocks, high %0d clks need %0d", name, act_bad, act_cnt, clks);
        end
        total++;
        if (get_bad != 0) begin
            bad++;
            $display("FAIL %s get timing: %0d wrong clocks", name, get_bad);
        end
        total++;
        if (gets != n) begin
            bad++;
            $display("FAIL %s get count: got %0d need %0d", name, gets, n);
        end
        total++;
        if (err_cnt != 0) begin
            bad++;
            $display("FAIL %s error: high %0d clks need 0", name, err_cnt);
        end

        // Receiver view: NRZI decode, drop stuffed bits, pack LSB first.
        rx_bytes_q.delete();
        prev = 1'b1; ones = 0; skip = 1'b0; cnt = 0; cur = 8'h00;
        for (int i = 0; i < lv.size(); i++) begin
            if (se[i]) break;
            rb = (lv[i] == prev);
            prev = lv[i];
            if (skip) begin
                skip = 1'b0;
                ones = 0;
            end else begin
                cur[cnt] = rb;
                cnt++;
                if (cnt == 8) begin
                    rx_bytes_q.push_back(cur);
                    cnt = 0;
                end
                ones = rb ? ones + 1 : 0;
                if (ones == 6) skip = 1'b1;
            end
        end
        $display("%s: cmd=%0d bytes=%0d active=%0d clks gets=%0d", name, cmd, n, act_cnt, gets);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (dp_out !== 1'b1) begin bad++; $display("FAIL reset dp: got %b need 1", dp_out); end
        total++; if (dm_out !== 1'b0) begin bad++; $display("FAIL reset dm: got %b need 0", dm_out); end
        total++; if (get_TX_packet_data !== 1'b0) begin bad++; $display("FAIL reset get: got %b need 0", get_TX_packet_data); end
        total++; if (TX_transfer_active !== 1'b0) begin bad++; $display("FAIL reset active: got %b need 0", TX_transfer_active); end
        total++; if (TX_error !== 1'b0) begin bad++; $display("FAIL reset error: got %b need 0", TX_error); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_ack();
        pay_q.delete();
        run_packet(3'd3, 8, "ack");
        total++;
        if (last_active_clks != 152) begin bad++; $display("FAIL ack length: got %0d need 152", last_active_clks); end
        total++;
        if (rx_bytes_q.size() != 2 || rx_bytes_q[0] !== 8'h80 || rx_bytes_q[1] !== 8'hD2) begin
            bad++;
            $display("FAIL ack decode: got %0d bytes first %h %h need 80 d2", rx_bytes_q.size(),
                     rx_bytes_q.size() > 0 ? rx_bytes_q[0] : 8'hxx, rx_bytes_q.size() > 1 ? rx_bytes_q[1] : 8'hxx);
        end
    endtask

    task automatic test_data0_empty();
        pay_q.delete();
        run_packet(3'd1, 8, "data0_empty");
        // SYNC, PID, two CRC bytes, then 3 EOP bit periods.
        total++;
        if (last_active_clks != 35 * CPB) begin bad++; $display("FAIL data0_empty length: got %0d need %0d", last_active_clks, 35 * CPB); end
        total++;
        if (rx_bytes_q.size() != 4 || rx_bytes_q[1] !== 8'hC3 || rx_bytes_q[2] !== 8'h00 || rx_bytes_q[3] !== 8'h00) begin
            bad++;
            $display("FAIL data0_empty decode: got %0d bytes need 80 c3 00 00", rx_bytes_q.size());
        end
    endtask

    task automatic test_data1_digits();
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
        run_packet(3'd2, 8, "data1_digits");
        total++;
        if (rx_bytes_q.size() != 13) begin
            bad++;
            $display("FAIL data1_digits size: got %0d bytes need 13", rx_bytes_q.size());
        end else if (rx_bytes_q[11] !== 8'hC8 || rx_bytes_q[12] !== 8'hB4) begin
            bad++;
            $display("FAIL data1_digits crc: got %h %h need c8 b4", rx_bytes_q[11], rx_bytes_q[12]);
        end
        total++;
        if (rx_bytes_q.size() != 13 || rx_bytes_q[2] !== 8'h31 || rx_bytes_q[10] !== 8'h39) begin
            bad++;
            $display("FAIL data1_digits payload: first/last payload bytes wrong, size %0d", rx_bytes_q.size());
        end
    endtask

    task automatic test_stuff_ff();
        pay_q.delete();
        pay_q.push_back(8'hFF);
        run_packet(3'd1, 8, "stuff_ff");
        // 5 bytes + 3 EOP periods, plus stuffs after data bit 3 and inside the 0xFF CRC high byte.
        total++;
        if (last_active_clks != (40 + 2 + 3) * CPB) begin
            bad++; $display("FAIL stuff_ff length: got %0d need %0d", last_active_clks, (40 + 2 + 3) * CPB);
        end
        total++;
        if (rx_bytes_q.size() != 5 || rx_bytes_q[2] !== 8'hFF || rx_bytes_q[3] !== 8'h00 || rx_bytes_q[4] !== 8'hFF) begin
            bad++;
            $display("FAIL stuff_ff decode: got %0d bytes need 80 c3 ff 00 ff", rx_bytes_q.size());
        end
    endtask

    task automatic test_error();
        int err_hi, side_bad;
        for (int c = 6; c <= 7; c++) begin
            err_hi = 0; side_bad = 0;
            @(negedge clk);
            TX_packet = 3'(c);
            @(negedge clk);
            TX_packet = 3'd0;
            for (int k = 0; k < 6; k++) begin
                if (TX_error === 1'b1) err_hi++;
                if (k == 0 && TX_error !== 1'b1) side_bad++;
                if (dp_out !== 1'b1 || dm_out !== 1'b0 || get_TX_packet_data !== 1'b0 || TX_transfer_active !== 1'b0) side_bad++;
                @(negedge clk);
            end
            total++;
            if (err_hi != 1) begin bad++; $display("FAIL error_%0d pulse: high %0d clks need 1", c, err_hi); end
            total++;
            if (side_bad != 0) begin bad++; $display("FAIL error_%0d idle outputs: %0d wrong clocks need 0", c, side_bad); end
            $display("error: cmd=%0d pulse=%0d clks", c, err_hi);
        end
    endtask

    task automatic test_handshakes();
        pay_q.delete();
        run_packet(3'd4, 4, "nak");
        run_packet(3'd5, 4, "stall");
    endtask

    task automatic test_back_to_back();
        pay_q.delete();
        repeat (3) pay_q.push_back(8'($urandom));
        run_packet(3'd2, 0, "b2b_first");
        pay_q.delete();
        repeat (2) pay_q.push_back(8'hFF);
        run_packet(3'd1, 0, "b2b_second");
        run_packet(3'd3, 8, "b2b_third");
    endtask

    task automatic test_random();
        logic [2:0] cmd;
        int n;
        for (int p = 0; p < 7; p++) begin
            cmd = 3'($urandom_range(5, 1));
            n = (p == 0) ? 64 : $urandom_range(20, 0);
            pay_q.delete();
            for (int i = 0; i < n; i++)
                pay_q.push_back(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
            run_packet(cmd, (p % 2 == 0) ? 0 : 8, "random");
        end
    endtask

    task automatic test_reset_mid();
        pay_q.delete();
        repeat (5) pay_q.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) buf_mem[rd_ptr + 6'(i)] = pay_q[i];
        @(negedge clk);
        TX_packet = 3'd1;
        buffer_occupancy = 7'd5;
        @(negedge clk);
        TX_packet = 3'd0;
        repeat (200) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({dp_out, dm_out, get_TX_packet_data, TX_transfer_active, TX_error} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_mid async: dp dm get act err got %b need 10000",
                     {dp_out, dm_out, get_TX_packet_data, TX_transfer_active, TX_error});
        end
        @(negedge clk);
        total++;
        if ({dp_out, dm_out, get_TX_packet_data, TX_transfer_active, TX_error} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_mid held: dp dm get act err got %b need 10000",
                     {dp_out, dm_out, get_TX_packet_data, TX_transfer_active, TX_error});
        end
        n_rst = 1'b1;
        $display("reset_mid: reset asserted during payload and released");
        pay_q.delete();
        repeat (3) pay_q.push_back(8'($urandom));
        run_packet(3'd1, 8, "after_reset");
        total++;
        if (rx_bytes_q.size() < 1 || rx_bytes_q[0] !== 8'h80) begin
            bad++;
            $display("FAIL after_reset sync: got %h need 80", rx_bytes_q.size() > 0 ? rx_bytes_q[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_empty();
        test_data1_digits();
        test_stuff_ff();
        test_error();
        test_handshakes();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
